n64adv2_vout_stage: RTL
=======================

# n64adv2_vout_stage

Parametrised video output stage between the PPU and the ADV7513 pins, running on the transmit video clock. It delays sync, DE and pixel data through a configurable, lane-aligned register pipeline. It applies sync polarity, DE-gated blanking and frame-synchronous muting. It also measures the outgoing raster (active width, active height, total line length) for controller status readback.

## Interface
Parameters
- color_width, 8, bits per colour channel
- channels, 3, number of colour channels in VD bus
- pipe_depth, 2, register stages on all video lanes; legal 1..4
- meas_width, 12, width of each raster measurement counter

Ports
- VCLK_Tx  in  1  transmit video clock; the only clock
- nVRST_Tx  in  1  reset, synchronous, active-low
- vsync_pol_i  in  1  1 = VSYNC_o active-low, 0 = active-high
- hsync_pol_i  in  1  1 = HSYNC_o active-low, 0 = active-high
- blank_en_i  in  1  1 = force VD to zero while DE is low
- mute_req_i  in  1  request black output (syncs and DE unaffected)
- VSYNC_i  in  1  vertical sync, active-high
- HSYNC_i  in  1  horizontal sync, active-high
- DE_i  in  1  data enable
- VD_i  in  channels*color_width  pixel data
- VSYNC_o  out  1  delayed, polarity-applied vsync
- HSYNC_o  out  1  delayed, polarity-applied hsync
- DE_o  out  1  delayed DE
- VD_o  out  channels*color_width  delayed, blanked/muted data
- mute_act_o  out  1  mute currently applied
- h_active_o  out  meas_width  DE-high cycles of the last line with DE
- v_active_o  out  meas_width  lines containing DE in the last frame
- h_total_o  out  meas_width  clocks between last two HSYNC_i rising edges
- meas_valid_o  out  1  measurements reflect a complete frame

## Operation
- Pipeline: pipe_depth stages per lane. Stage 1 captures inputs. Polarity, blanking and mute are applied combinationally in front of the last stage, so every output register is a flop feeding a pin.
- Polarity: VSYNC_o = delayed VSYNC_i XOR vsync_pol_i (same for HSYNC). Polarity inputs are sampled at the last stage without resynchronisation; changes take effect on the next clock.
- Blanking: if blank_en_i=1 and delayed DE=0, VD_o=0.
- Mute: mute_req_i is latched into mute_act_o only on a VSYNC_i rising edge (input side), so mute never starts or stops mid-frame. While mute_act_o=1, VD_o=0.
- Measurement, on the input side:
  - hcnt counts clocks and restarts at 1 on each HSYNC_i rising edge. Its previous value is stored into h_total_o.
  - decnt counts DE_i-high cycles within a line. On DE_i falling edge, decnt → h_active_o, and the line flag is set.
  - On HSYNC_i rising edge, if the line flag is set, lcnt increments and the flag clears.
  - On VSYNC_i rising edge, lcnt → v_active_o and lcnt clears.
  - All counters saturate at 2^meas_width−1; they do not wrap.
- meas_valid_o FSM: M_RST → M_SYNC (first VSYNC edge) → M_VALID (second VSYNC edge). Reset returns to M_RST.
- Simultaneous VSYNC and HSYNC rising edges: the line-flag increment is applied before the lcnt → v_active_o transfer, so the closing line is counted in the finished frame.

## Timing
- Latency VSYNC_i/HSYNC_i/DE_i/VD_i → outputs: exactly pipe_depth clocks, identical on all lanes.
- mute_act_o updates 1 clock after the VSYNC_i rising-edge sample. It affects VD_o for pixels entering the pipe from that clock on.
- Measurement outputs update 1 clock after the detected edge (edge detect uses a 1-cycle delayed copy of the input).
- Reset (nVRST_Tx=0 at a clock edge):
  - All pipe stages, VD_o, DE_o, mute_act_o, h_active_o, v_active_o, h_total_o and meas_valid_o go to 0.
  - VSYNC_o = vsync_pol_i and HSYNC_o = hsync_pol_i, i.e. the inactive level.
  - A reset mid-frame discards partial counts. The first VSYNC edge after release gives M_SYNC, not valid.

## Structure
- Shared package/header n64adv2_vout_pkg.vh: measurement FSM state encodings (M_RST, M_SYNC, M_VALID) and the saturating-max constant macro.
- One sub-module, n64adv2_raster_meas: edge detection, counters and valid FSM. The top holds the pipeline, polarity, blanking and mute logic.

## Test plan
- Latency: pipe_depth=3, single-cycle DE_i pulse with VD_i=24'hA5A5A5 → DE_o high and VD_o=24'hA5A5A5 exactly 3 clocks later; syncs aligned identically.
- Polarity/blanking: vsync_pol_i=1, blank_en_i=1, VD_i=24'hFFFFFF with DE_i=0 → VSYNC_o idles 1, VD_o=0; with blank_en_i=0 → VD_o=24'hFFFFFF.
- Mute mid-frame: assert mute_req_i at line 100 → VD_o unchanged until the next VSYNC_i rising edge, then 0 for the whole following frame; deassert the same way.
- Measurement: 720p raster (1650 total, 1280 active, 720 active lines) → after the 2nd VSYNC, meas_valid_o=1, h_total_o=1650, h_active_o=1280, v_active_o=720.
- Saturation: meas_width=10, h_total 1650 → h_total_o=1023, h_active_o=1023.
- Reset mid-frame: assert nVRST_Tx=0 for 1 clock at line 300 → all outputs at reset values next clock; meas_valid_o returns to 1 only after two further VSYNC edges.

Source files
------------

// File: rtl/n64adv2_vout_pkg.sv
// Shared definitions for the n64adv2 video output stage: raster measurement
// FSM states and the saturation limit helper used by the measurement counters.
package n64adv2_vout_pkg;

    typedef enum logic [1:0] {
        M_RST   = 2'd0,
        M_SYNC  = 2'd1,
        M_VALID = 2'd2
    } meas_state_t;

    // All-ones value of a w-bit counter; counters stop here instead of wrapping.
    function automatic logic [31:0] sat_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/n64adv2_raster_meas.sv
// Input-side raster measurement: sync/DE edge detection, saturating counters
// for line length, active width and active lines, and the valid FSM.
module n64adv2_raster_meas
    import n64adv2_vout_pkg::*;
#(
    parameter int meas_width = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_vsync,
    input  logic                  i_hsync,
    input  logic                  i_de,
    output logic                  o_vs_rise,
    output logic [meas_width-1:0] o_h_active,
    output logic [meas_width-1:0] o_v_active,
    output logic [meas_width-1:0] o_h_total,
    output logic                  o_meas_valid
);

    localparam logic [meas_width-1:0] CNT_MAX = meas_width'(sat_max(meas_width));
    localparam logic [meas_width-1:0] CNT_ONE = meas_width'(1);

    logic                  r_vs_d, r_hs_d, r_de_d;
    logic [meas_width-1:0] r_hcnt, r_decnt, r_lcnt;
    logic                  r_line_flag;
    meas_state_t           r_state;

    logic                  w_vs_rise, w_hs_rise, w_de_fall, w_line_done;
    logic [meas_width-1:0] w_lcnt_next;

    assign w_vs_rise   = i_vsync & ~r_vs_d;
    assign w_hs_rise   = i_hsync & ~r_hs_d;
    assign w_de_fall   = ~i_de & r_de_d;
    assign w_line_done = w_hs_rise & r_line_flag;
    // The closing line is folded in before a same-cycle VSYNC transfer.
    assign w_lcnt_next = (w_line_done && r_lcnt != CNT_MAX) ? r_lcnt + CNT_ONE : r_lcnt;
    assign o_vs_rise   = w_vs_rise;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_vs_d       <= 1'b0;
            r_hs_d       <= 1'b0;
            r_de_d       <= 1'b0;
            r_hcnt       <= '0;
            r_decnt      <= '0;
            r_lcnt       <= '0;
            r_line_flag  <= 1'b0;
            r_state      <= M_RST;
            o_h_active   <= '0;
            o_v_active   <= '0;
            o_h_total    <= '0;
            o_meas_valid <= 1'b0;
        end else begin
            r_vs_d <= i_vsync;
            r_hs_d <= i_hsync;
            r_de_d <= i_de;

            if (w_hs_rise) begin
                o_h_total <= r_hcnt;
                r_hcnt    <= CNT_ONE;
            end else if (r_hcnt != CNT_MAX) begin
                r_hcnt <= r_hcnt + CNT_ONE;
            end

            if (w_de_fall) begin
                o_h_active <= r_decnt;
                r_decnt    <= '0;
            end else if (i_de && r_decnt != CNT_MAX) begin
                r_decnt <= r_decnt + CNT_ONE;
            end

            if (w_de_fall)      r_line_flag <= 1'b1;
            else if (w_hs_rise) r_line_flag <= 1'b0;

            if (w_vs_rise) begin
                o_v_active <= w_lcnt_next;
                r_lcnt     <= '0;
                case (r_state)
                    M_RST:   r_state <= M_SYNC;
                    default: begin
                        r_state      <= M_VALID;
                        o_meas_valid <= 1'b1;
                    end
                endcase
            end else begin
                r_lcnt <= w_lcnt_next;
            end
        end
    end

endmodule

// File: rtl/n64adv2_vout_stage.sv
// Video output stage towards the ADV7513: lane-aligned delay pipe with
// polarity, DE blanking and frame-synchronous mute on the last (pin) stage.
module n64adv2_vout_stage
    import n64adv2_vout_pkg::*;
#(
    parameter int color_width = 8,
    parameter int channels    = 3,
    parameter int pipe_depth  = 2,
    parameter int meas_width  = 12
) (
    input  logic                              VCLK_Tx,
    input  logic                              nVRST_Tx,
    input  logic                              vsync_pol_i,
    input  logic                              hsync_pol_i,
    input  logic                              blank_en_i,
    input  logic                              mute_req_i,
    input  logic                              VSYNC_i,
    input  logic                              HSYNC_i,
    input  logic                              DE_i,
    input  logic [channels*color_width-1:0]   VD_i,
    output logic                              VSYNC_o,
    output logic                              HSYNC_o,
    output logic                              DE_o,
    output logic [channels*color_width-1:0]   VD_o,
    output logic                              mute_act_o,
    output logic [meas_width-1:0]             h_active_o,
    output logic [meas_width-1:0]             v_active_o,
    output logic [meas_width-1:0]             h_total_o,
    output logic                              meas_valid_o
);

    localparam int VDW = channels * color_width;
    localparam int LW  = VDW + 4;  // lane = {mute, vsync, hsync, de, vd}

    logic          r_mute_act;
    logic          w_vs_rise;
    logic [LW-1:0] w_lane_in, w_lane_pre;

    // Mute travels with the pixels so it switches exactly at a frame boundary.
    assign w_lane_in  = {r_mute_act, VSYNC_i, HSYNC_i, DE_i, VD_i};
    assign mute_act_o = r_mute_act;

    generate
        if (pipe_depth > 1) begin : g_dly
            logic [LW-1:0] r_dly [pipe_depth-1];

            always_ff @(posedge VCLK_Tx) begin
                if (!nVRST_Tx) begin
                    // NOTE: these stages are plain flops rather than a RAM, so they are
                    // reset; otherwise stale DE/data would reach the pins after reset.
                    for (int i = 0; i < pipe_depth - 1; i++) r_dly[i] <= '0;
                end else begin
                    r_dly[0] <= w_lane_in;
                    for (int i = 1; i < pipe_depth - 1; i++) r_dly[i] <= r_dly[i-1];
                end
            end

            assign w_lane_pre = r_dly[pipe_depth-2];
        end else begin : g_nodly
            assign w_lane_pre = w_lane_in;
        end
    endgenerate

    always_ff @(posedge VCLK_Tx) begin
        if (!nVRST_Tx) begin
            r_mute_act <= 1'b0;
            VSYNC_o    <= vsync_pol_i;
            HSYNC_o    <= hsync_pol_i;
            DE_o       <= 1'b0;
            VD_o       <= '0;
        end else begin
            if (w_vs_rise) r_mute_act <= mute_req_i;
            VSYNC_o <= w_lane_pre[LW-2] ^ vsync_pol_i;
            HSYNC_o <= w_lane_pre[LW-3] ^ hsync_pol_i;
            DE_o    <= w_lane_pre[LW-4];
            VD_o    <= (w_lane_pre[LW-1] || (blank_en_i && !w_lane_pre[LW-4]))
                       ? '0 : w_lane_pre[VDW-1:0];
        end
    end

    n64adv2_raster_meas #(
        .meas_width(meas_width)
    ) u_meas (
        .i_clk        (VCLK_Tx),
        .i_rst_n      (nVRST_Tx),
        .i_vsync      (VSYNC_i),
        .i_hsync      (HSYNC_i),
        .i_de         (DE_i),
        .o_vs_rise    (w_vs_rise),
        .o_h_active   (h_active_o),
        .o_v_active   (v_active_o),
        .o_h_total    (h_total_o),
        .o_meas_valid (meas_valid_o)
    );

endmodule
